// File: rtl/if_stage.sv
// ============================================================================
// if_stage: RV32IM instruction fetch. Owns the PC, absorbs i_cache miss stalls,
// applies execute-stage redirects (also during a miss), fills the IF/ID register.
// Optional: IF_ALIGN_CHECK_EN enables the sticky MISALIGN flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_BUSYWAIT,
    input  logic [31:0] I_INSTRUCTION,
    output logic [31:0] I_ADDR,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IFID_INSTR,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4,
    output logic        IFID_VALID,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_MISS       = 2'd1,
        S_MISS_REDIR = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pend_pc, w_pend_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_ifpc, w_ifpc_nxt;
    logic [31:0] r_ifpc4, w_ifpc4_nxt;
    logic        r_valid, w_valid_nxt;

    logic [31:0] w_tgt;
    logic [31:0] w_pc4;

    assign w_tgt = BRANCH_TARGET & ~32'h3;
    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_pc;
        w_instr_nxt = r_instr;
        w_ifpc_nxt  = r_ifpc;
        w_ifpc4_nxt = r_ifpc4;
        w_valid_nxt = r_valid;

        if (I_BUSYWAIT) begin
            // PC must not move: the cache tags its fill with the live address
            if (!STALL) begin
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
            end
            if (BRANCH_TAKEN) begin
                w_pend_nxt  = w_tgt;
                w_state_nxt = S_MISS_REDIR;
            end else if (r_state != S_MISS_REDIR) begin
                w_state_nxt = S_MISS;
            end
        end else if (r_state == S_MISS_REDIR) begin
            w_pc_nxt    = BRANCH_TAKEN ? w_tgt : r_pend_pc;
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_RUN;
        end else begin
            w_state_nxt = S_RUN;
            if (BRANCH_TAKEN) begin
                w_pc_nxt    = w_tgt;
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
            end else if (!STALL) begin
                w_instr_nxt = I_INSTRUCTION;
                w_ifpc_nxt  = r_pc;
                w_ifpc4_nxt = w_pc4;
                w_valid_nxt = 1'b1;
                w_pc_nxt    = w_pc4;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_pend_pc <= 32'h0;
            r_instr   <= NOP_INSTR;
            r_ifpc    <= 32'h0;
            r_ifpc4   <= 32'h0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_nxt;
            r_instr   <= w_instr_nxt;
            r_ifpc    <= w_ifpc_nxt;
            r_ifpc4   <= w_ifpc4_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_misalign <= 1'b0;
        end else if (BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign MISALIGN = r_misalign;
`else
    assign MISALIGN = 1'b0;
`endif

    assign I_ADDR     = r_pc;
    assign IFID_INSTR = r_instr;
    assign IFID_PC    = r_ifpc;
    assign IFID_PC4   = r_ifpc4;
    assign IFID_VALID = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage: scoreboard bench for if_stage with a cache-word model and a
// pending-redirect reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        I_BUSYWAIT = 1'b0;
    logic [31:0] I_INSTRUCTION;
    logic [31:0] I_ADDR;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'h0;
    logic [31:0] IFID_INSTR;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_PC4;
    logic        IFID_VALID;
    logic        MISALIGN;

    if_stage u_dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .I_BUSYWAIT    (I_BUSYWAIT),
        .I_INSTRUCTION (I_INSTRUCTION),
        .I_ADDR        (I_ADDR),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IFID_INSTR    (IFID_INSTR),
        .IFID_PC       (IFID_PC),
        .IFID_PC4      (IFID_PC4),
        .IFID_VALID    (IFID_VALID),
        .MISALIGN      (MISALIGN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h0000_0013;
    endfunction

    assign I_INSTRUCTION = mem_word(I_ADDR);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t q_exp[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: architectural PC, IF/ID contents, and an optional
    // redirect remembered while the cache is busy.
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_pend_pc;
    logic        m_valid, m_pend, m_mis;

    task automatic model_step();
        logic [31:0] tgt;
        tgt = BRANCH_TARGET & ~32'h3;
        if (!RESET) begin
            m_pc = 32'h0; m_instr = C_NOP; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
            m_valid = 1'b0; m_pend = 1'b0; m_pend_pc = 32'h0; m_mis = 1'b0;
        end else begin
`ifdef IF_ALIGN_CHECK_EN
            if (BRANCH_TAKEN && BRANCH_TARGET[1:0] != 2'b00) m_mis = 1'b1;
`endif
            if (I_BUSYWAIT) begin
                if (!STALL) begin m_instr = C_NOP; m_valid = 1'b0; end
                if (BRANCH_TAKEN) begin m_pend = 1'b1; m_pend_pc = tgt; end
            end else if (m_pend) begin
                m_pc = BRANCH_TAKEN ? tgt : m_pend_pc;
                m_instr = C_NOP; m_valid = 1'b0; m_pend = 1'b0;
            end else if (BRANCH_TAKEN) begin
                m_pc = tgt; m_instr = C_NOP; m_valid = 1'b0;
            end else if (!STALL) begin
                m_instr = mem_word(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end
        q_exp.push_back('{addr: m_pc, instr: m_instr, pc: m_ifpc, pc4: m_ifpc4,
                          valid: m_valid, mis: m_mis});
    endtask

    // One cycle of stimulus: drive on negedge, model predicts the next posedge.
    task automatic cyc(input logic rst, input logic busy, input logic stall,
                       input logic bt, input logic [31:0] tgt);
        @(negedge CLK);
        RESET = rst; I_BUSYWAIT = busy; STALL = stall;
        BRANCH_TAKEN = bt; BRANCH_TARGET = tgt;
        model_step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                vectors++;
                if (I_ADDR !== e.addr) begin
                    miscompares++;
                    $display("FAIL i_addr t=%0t got %h want %h", $time, I_ADDR, e.addr);
                end
                if (IFID_INSTR !== e.instr) begin
                    miscompares++;
                    $display("FAIL ifid_instr t=%0t got %h want %h", $time, IFID_INSTR, e.instr);
                end
                if (IFID_PC !== e.pc) begin
                    miscompares++;
                    $display("FAIL ifid_pc t=%0t got %h want %h", $time, IFID_PC, e.pc);
                end
                if (IFID_PC4 !== e.pc4) begin
                    miscompares++;
                    $display("FAIL ifid_pc4 t=%0t got %h want %h", $time, IFID_PC4, e.pc4);
                end
                if (IFID_VALID !== e.valid) begin
                    miscompares++;
                    $display("FAIL ifid_valid t=%0t got %b want %b", $time, IFID_VALID, e.valid);
                end
                if (MISALIGN !== e.mis) begin
                    miscompares++;
                    $display("FAIL misalign t=%0t got %b want %b", $time, MISALIGN, e.mis);
                end
            end
        end
    end

    initial begin : stimulus
        logic bt, busy, stall, rst;
        logic [31:0] tgt;
        int burst;

        // reset held for 3 cycles, then straight-line hits 0,4,8,C
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // miss at 0x40 lasting 5 cycles
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // redirect to 0x200 in the 2nd busy cycle of a miss at 0x80
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // busy falling together with a redirect
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h340);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // stall + redirect together, then stall alone
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // misaligned target, sticky until reset
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // randomized traffic with miss bursts
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 5) == 0) burst = $urandom_range(1, 6);
            busy  = (burst != 0);
            if (burst != 0) burst--;
            stall = ($urandom_range(0, 5) == 0);
            bt    = ($urandom_range(0, 7) == 0);
            tgt   = $urandom();
            if ($urandom_range(0, 3) != 0) tgt = {24'h0, tgt[7:0]};
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8 | {30'h0, tgt[1:0]};
            rst   = ($urandom_range(0, 399) != 0);
            cyc(rst, busy, stall, bt, tgt);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int w = 0; w < 10 && q_exp.size() != 0; w++) @(posedge CLK);
        #2;
        if (q_exp.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32IM pipeline. It sits directly upstream of `i_cache`: it owns the PC, drives the cache address, and absorbs cache miss stalls. It applies branch/jump redirects from the execute stage, including redirects that arrive during a miss, and fills the IF/ID pipeline register consumed by decode.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- `CLK` in 1: single clock; all state updates on posedge
- `RESET` in 1: asynchronous, active-low reset
- `I_BUSYWAIT` in 1: cache busy, from `i_cache` BUSYWAIT
- `I_INSTRUCTION` in 32: fetched word, from `i_cache` INSTRUCTION
- `I_ADDR` out 32: fetch address to `i_cache` ADDR; always equals the PC register
- `STALL` in 1: hazard-unit hold of PC and IF/ID
- `BRANCH_TAKEN` in 1: redirect request; qualifies `BRANCH_TARGET`
- `BRANCH_TARGET` in 32: redirect address
- `IFID_INSTR` out 32: registered instruction
- `IFID_PC` out 32: registered PC of `IFID_INSTR`
- `IFID_PC4` out 32: registered PC+4
- `IFID_VALID` out 1: 1 = real instruction, 0 = bubble
- `MISALIGN` out 1: sticky misaligned-target flag; only meaningful with the macro

## Operation
- States: RUN, MISS, MISS_REDIR. Pending register PEND_PC (32 bit).
- Bubble means IFID_INSTR=NOP_INSTR, IFID_VALID=0, IFID_PC/IFID_PC4 unchanged.
- PC and I_ADDR never change while I_BUSYWAIT=1. The cache tags its fill with the live address, so this rule is mandatory.

RUN with I_BUSYWAIT=0, priority order:
1. BRANCH_TAKEN: PC<=target, IF/ID<=bubble.
2. STALL: PC and IF/ID hold.
3. Otherwise: IF/ID<={I_INSTRUCTION, PC, PC+4, 1}, PC<=PC+4.

Any state with I_BUSYWAIT=1:
- PC holds.
- IF/ID holds if STALL=1, otherwise IF/ID<=bubble.
- BRANCH_TAKEN: PEND_PC<=target, go to MISS_REDIR. The newest redirect overwrites an older pending one.
- Without BRANCH_TAKEN: RUN goes to MISS; MISS_REDIR stays.

I_BUSYWAIT=0 in MISS: go to RUN and act exactly as in RUN this cycle.

I_BUSYWAIT=0 in MISS_REDIR:
- The fetched word is discarded.
- If BRANCH_TAKEN=1, PC<=BRANCH_TARGET; otherwise PC<=PEND_PC.
- IF/ID<=bubble; go to RUN. STALL is ignored this cycle.

Other rules:
- PC+4 is 32-bit modulo: 32'hFFFF_FFFC → 32'h0000_0000. The same applies to IFID_PC4.
- Targets always have bits [1:0] forced to 0 before loading the PC or PEND_PC.

## Timing
- Reset (RESET=0, async) sets PC=RESET_PC, IFID_INSTR=NOP_INSTR, IFID_PC=0, IFID_PC4=0, IFID_VALID=0, MISALIGN=0, PEND_PC=0, state RUN. A pending redirect is dropped.
- Release is synchronous: the first fetch occurs at the first posedge with RESET=1.
- Hit latency: the word at PC appears in IF/ID at the next posedge. Throughput is 1 instruction per cycle.
- Redirect penalty on a hit is exactly 1 bubble.
- `i_cache` updates BUSYWAIT on negedge. A miss on a new PC is therefore visible as I_BUSYWAIT=1 at the following posedge, and if_stage samples only at posedge.
- Miss: IFID_VALID=0 for every cycle I_BUSYWAIT=1. The instruction is captured on the first posedge with I_BUSYWAIT=0.
- Simultaneous events:
  - STALL and BRANCH_TAKEN together: the redirect wins.
  - I_BUSYWAIT falling and BRANCH_TAKEN in the same cycle: the redirect wins and no instruction is captured.

## Configuration
- `IF_ALIGN_CHECK_EN` defined: a redirect with BRANCH_TARGET[1:0]≠0 sets MISALIGN=1, held until reset. The PC is still loaded with the masked target.
- Not defined: MISALIGN is tied 0 and misaligned low bits are masked silently.

## Test plan
- Reset sequence: hold RESET=0 for 3 cycles with RESET_PC=0, then release, with cache always hit. Expected: IFID_PC steps 0,4,8,C on consecutive cycles with IFID_VALID=1; during reset, IFID_INSTR=32'h13 and IFID_VALID=0.
- Miss: a miss at PC=0x40 with I_BUSYWAIT high for 5 cycles. Expected: I_ADDR stays 0x40 and IFID_VALID=0 for 5 cycles, then IFID_PC=0x40 with IFID_VALID=1 on the first idle cycle.
- Redirect during a miss: pulse BRANCH_TAKEN with target 0x200 in the 2nd busy cycle of a miss at 0x80. Expected: I_ADDR remains 0x80 until busy drops; the 0x80 word is never valid in IF/ID; the next I_ADDR is 0x200.
- Redirect plus stall: hit path with STALL=1 and BRANCH_TAKEN=1 (target 0x100) in the same cycle. Expected: PC=0x100, one bubble. STALL alone holds IFID contents for N cycles.
- PC wrap: force PC to 0xFFFF_FFFC via redirect. Expected: IFID_PC4=0 and the next I_ADDR=0.
- Alignment check: with `IF_ALIGN_CHECK_EN` defined, target 0x102 gives PC=0x100 and MISALIGN=1, which stays 1 until RESET=0. Without the macro, MISALIGN stays 0.
